// File: rtl/mmio_uart_tx_if.sv
// Core data-bus port for the memory-mapped UART transmitter.
interface mmio_uart_tx_if;
    logic [31:0] dataAddr;
    logic [31:0] writeData;
    logic        we;
    logic [2:0]  f3;
    logic        hit;
    logic [31:0] readData;

    modport master (output dataAddr, writeData, we, f3, input  hit, readData);
    modport slave  (input  dataAddr, writeData, we, f3, output hit, readData);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: 16-byte register window, TX FIFO,
// programmable bit period, serialiser with back-to-back frames.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          txd,
    output logic          txEmpty
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} txStateT;

    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [CNT_W-1:0] count, countD;
    logic             ovf;
    logic [15:0]      div;

    txStateT     state, nextState;
    logic [7:0]  shreg, shregD;
    logic [15:0] bitDiv, bitDivD, cycleCnt, cycleCntD;
    logic [2:0]  bitIdx, bitIdxD;
    logic        txdD, txEmptyD, pop;

    logic [1:0] regSel;
    logic       fifoEmpty, fifoFull, busy, bitEnd;
    logic       wrData, wrStatus, wrDiv, pushOk;
    logic       unusedBits;

    // Window decode
    assign regSel    = bus.dataAddr[3:2];
    assign bus.hit   = (bus.dataAddr[31:4] == BASE_ADDR[31:4]);
    assign wrData    = bus.we & bus.hit & (regSel == REG_DATA);
    assign wrStatus  = bus.we & bus.hit & (regSel == REG_STATUS);
    assign wrDiv     = bus.we & bus.hit & (regSel == REG_DIV);
    assign unusedBits = ^{bus.f3, bus.writeData[31:16], bus.dataAddr[1:0]};

    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == FULL_CNT);
    assign busy      = (state != IDLE);
    assign bitEnd    = (cycleCnt == bitDiv - 16'd1);

    // A push into a full FIFO survives only if the serialiser pops that same edge
    assign pushOk = wrData & (~fifoFull | pop);
    assign countD = count + CNT_W'(pushOk) - CNT_W'(pop);

    always_comb begin
        bus.readData = '0;
        if (bus.hit) begin
            case (regSel)
                REG_STATUS: bus.readData = {20'd0, 4'(count), 4'd0, ovf, fifoEmpty, fifoFull, busy};
                REG_DIV:    bus.readData = {16'd0, div};
                default:    bus.readData = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) fifoMem[wrPtr] <= bus.writeData[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            ovf   <= 1'b0;
            div   <= DIV_RESET;
        end else begin
            if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)    rdPtr <= rdPtr + PTR_W'(1);
            count <= countD;
            if (wrData && fifoFull && !pop) ovf <= 1'b1;
            else if (wrStatus)              ovf <= 1'b0;
            if (wrDiv) div <= bus.writeData[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (!fifoEmpty) nextState = START;
            START:   if (bitEnd) nextState = DATA;
            DATA:    if (bitEnd && bitIdx == 3'd7) nextState = STOP;
            STOP:    if (bitEnd) nextState = fifoEmpty ? IDLE : START;
            default: nextState = IDLE;
        endcase
    end

    // Datapath updates; txd is computed from the next state so the flop leads the frame
    always_comb begin
        pop       = 1'b0;
        shregD    = shreg;
        bitDivD   = bitDiv;
        cycleCntD = cycleCnt;
        bitIdxD   = bitIdx;
        if (state != IDLE) cycleCntD = bitEnd ? 16'd0 : cycleCnt + 16'd1;
        if (nextState == START && state != START) begin
            pop       = 1'b1;
            shregD    = fifoMem[rdPtr];
            bitDivD   = (div == 16'd0) ? 16'd1 : div;
            cycleCntD = 16'd0;
        end
        if (state == START && nextState == DATA) bitIdxD = 3'd0;
        if (state == DATA && bitEnd) begin
            shregD  = {1'b0, shreg[7:1]};
            bitIdxD = bitIdx + 3'd1;
        end
        case (nextState)
            START:   txdD = 1'b0;
            DATA:    txdD = shregD[0];
            default: txdD = 1'b1;
        endcase
        txEmptyD = (nextState == IDLE) && (countD == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txd      <= 1'b1;
            txEmpty  <= 1'b1;
            shreg    <= '0;
            bitDiv   <= 16'd1;
            cycleCnt <= '0;
            bitIdx   <= '0;
        end else begin
            txd      <= txdD;
            txEmpty  <= txEmptyD;
            shreg    <= shregD;
            bitDiv   <= bitDivD;
            cycleCnt <= cycleCntD;
            bitIdx   <= bitIdxD;
        end
    end
endmodule
